permute_sched_fsm: RTL
======================

Name: permute_sched_fsm

Overview:
- Central sequencer between the input SIPO stage and the output PISO stage of the SHAKE core.
- Takes full-block handshakes from the load stage and drives absorb into the Keccak state, then runs ROUNDS permutation rounds.
- After the last input block, it repeats squeeze and permute cycles into the output buffer until the requested output length is covered.

Parameters:
- ROUNDS, 24, Keccak-f rounds per permutation.
- OUT_LEN_W, 32, width of output_length and of the remaining-bits counter.
- RATE128, 1344, SHAKE128 rate in bits.
- RATE256, 1088, SHAKE256 rate in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- header_valid  in  1  one-cycle pulse; header registers updated this cycle.
- mode  in  1  0 = SHAKE128, 1 = SHAKE256; sampled with header_valid.
- output_length  in  OUT_LEN_W  requested output bits; sampled with header_valid.
- input_buffer_ready  in  1  level; SIPO holds a full block.
- last_block_in_buffer  in  1  qualifies input_buffer_ready; block is the final padded block.
- input_buffer_ready_clr  out  1  pulse; block consumed, load stage clears its ready flag.
- state_reset  out  1  pulse; zero the Keccak state.
- absorb_enable  out  1  pulse; XOR the SIPO block into the state rate lanes.
- round_enable  out  1  apply one round this cycle.
- round_index  out  5  round constant index, valid when round_enable = 1.
- output_buffer_ready  in  1  level; PISO still holds undrained data.
- output_buffer_load  out  1  pulse; copy the rate lanes into the PISO.
- last_output_block  out  1  qualifies output_buffer_load; final block of the request.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, any state): state goes to IDLE, round counter = 0, remaining = 0, mode and last registers = 0, every output = 0.
- State machine:
  - IDLE: on header_valid, assert state_reset, latch mode, load remaining = output_length, go to WAIT_INPUT.
  - WAIT_INPUT: when input_buffer_ready = 1, latch last_block_in_buffer into last_r, go to ABSORB.
  - ABSORB (1 cycle): absorb_enable = 1 and input_buffer_ready_clr = 1; round counter = 0; go to PERMUTE.
  - PERMUTE: round_enable = 1, round_index = counter, counter increments each cycle.
    - When counter = ROUNDS-1 and last_r = 0: go to WAIT_INPUT.
    - When counter = ROUNDS-1 and last_r = 1 and remaining = 0: go to IDLE.
    - When counter = ROUNDS-1 and last_r = 1 and remaining > 0: go to SQUEEZE.
  - SQUEEZE: wait while output_buffer_ready = 1. When output_buffer_ready = 0:
    - pulse output_buffer_load;
    - last_output_block = (remaining <= rate);
    - remaining = saturating(remaining - rate), floor 0;
    - if last_output_block, go to IDLE; else clear counter and go to PERMUTE.
- Rate is RATE128 if mode_r = 0, else RATE256. Subtraction is at OUT_LEN_W bits and never wraps.
- Latency:
  - input_buffer_ready high at cycle t gives ABSORB at t+1 and rounds t+2 .. t+1+ROUNDS.
  - Next WAIT_INPUT or SQUEEZE is at t+2+ROUNDS.
  - With output_buffer_ready = 0, the load pulse is in that same SQUEEZE cycle.
- Handshake rules:
  - input_buffer_ready is only sampled in WAIT_INPUT.
  - The clr pulse is exactly one cycle; the load stage drops ready on the following cycle.
  - output_buffer_load never fires while output_buffer_ready = 1.
- Boundary cases:
  - header_valid outside IDLE is ignored.
  - input_buffer_ready held high through ABSORB/PERMUTE is not re-consumed; only one absorb per WAIT_INPUT visit.
  - If output_length is an exact multiple of rate, the last block is the one where remaining = rate; no trailing extra permutation.
  - output_length = 0 absorbs all input blocks and produces no output load.
  - round_index holds 0 whenever round_enable = 0.

Test Plan:
- Reset mid-PERMUTE at round 10 -> next cycle: IDLE, busy = 0, all pulses 0, round_index = 0.
- mode = 0, output_length = 256, single last block, output_buffer_ready = 0 ->
  - state_reset at header;
  - absorb + clr 1 cycle after ready;
  - 24 round_enable cycles with index 0..23;
  - one output_buffer_load with last_output_block = 1;
  - back to IDLE.
- mode = 1, 3 input blocks (last flag on 3rd), output_length = 1088 -> three absorb/24-round groups, exactly one load with last = 1, no fourth permutation.
- mode = 0, output_length = 3000 ->
  - loads at remaining 3000, 1656, 312;
  - last_output_block = 1 only on the 3rd load;
  - 24 rounds between each load.
- output_buffer_ready held 1 for 50 cycles in SQUEEZE -> no load until it drops, then load in that cycle.
- output_length = 0, header_valid pulsed during PERMUTE -> no output load, header ignored, IDLE after 24 rounds.

Source files
------------

// File: rtl/permute_sched_fsm.sv
// Sequencer for the SHAKE core: absorbs SIPO blocks, runs the Keccak-f rounds,
// then alternates squeeze/permute into the PISO until the requested length is covered.
module permute_sched_fsm #(
  parameter int ROUNDS    = 24,
  parameter int OUT_LEN_W = 32,
  parameter int RATE128   = 1344,
  parameter int RATE256   = 1088
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 header_valid,
  input  logic                 mode,
  input  logic [OUT_LEN_W-1:0] output_length,
  input  logic                 input_buffer_ready,
  input  logic                 last_block_in_buffer,
  output logic                 input_buffer_ready_clr,
  output logic                 state_reset,
  output logic                 absorb_enable,
  output logic                 round_enable,
  output logic [4:0]           round_index,
  input  logic                 output_buffer_ready,
  output logic                 output_buffer_load,
  output logic                 last_output_block,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_INPUT = 3'd1,
    S_ABSORB     = 3'd2,
    S_PERMUTE    = 3'd3,
    S_SQUEEZE    = 3'd4
  } state_t;

  localparam logic [4:0]           LAST_ROUND = 5'(ROUNDS - 1);
  localparam logic [OUT_LEN_W-1:0] RATE128_W  = OUT_LEN_W'(RATE128);
  localparam logic [OUT_LEN_W-1:0] RATE256_W  = OUT_LEN_W'(RATE256);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [4:0]           r_round;
  logic [4:0]           w_round_nxt;
  logic [OUT_LEN_W-1:0] r_remaining;
  logic [OUT_LEN_W-1:0] w_remaining_nxt;
  logic                 r_mode;
  logic                 w_mode_nxt;
  logic                 r_last;
  logic                 w_last_nxt;

  logic [OUT_LEN_W-1:0] w_rate;
  logic                 w_rem_le_rate;
  logic [OUT_LEN_W-1:0] w_rem_sub;

  // Remaining-bits arithmetic saturates at zero instead of wrapping.
  assign w_rate        = r_mode ? RATE256_W : RATE128_W;
  assign w_rem_le_rate = (r_remaining <= w_rate);
  assign w_rem_sub     = w_rem_le_rate ? {OUT_LEN_W{1'b0}} : (r_remaining - w_rate);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_round     <= 5'd0;
      r_remaining <= {OUT_LEN_W{1'b0}};
      r_mode      <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_round     <= w_round_nxt;
      r_remaining <= w_remaining_nxt;
      r_mode      <= w_mode_nxt;
      r_last      <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt            = r_state;
    w_round_nxt            = r_round;
    w_remaining_nxt        = r_remaining;
    w_mode_nxt             = r_mode;
    w_last_nxt             = r_last;
    input_buffer_ready_clr = 1'b0;
    state_reset            = 1'b0;
    absorb_enable          = 1'b0;
    round_enable           = 1'b0;
    round_index            = 5'd0;
    output_buffer_load     = 1'b0;
    last_output_block      = 1'b0;
    busy                   = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (header_valid) begin
          state_reset     = 1'b1;
          w_mode_nxt      = mode;
          w_remaining_nxt = output_length;
          w_last_nxt      = 1'b0;
          w_state_nxt     = S_WAIT_INPUT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_INPUT: begin
        if (input_buffer_ready) begin
          w_last_nxt  = last_block_in_buffer;
          w_state_nxt = S_ABSORB;
        end else begin
          w_state_nxt = S_WAIT_INPUT;
        end
      end
      S_ABSORB: begin
        absorb_enable          = 1'b1;
        input_buffer_ready_clr = 1'b1;
        w_round_nxt            = 5'd0;
        w_state_nxt            = S_PERMUTE;
      end
      S_PERMUTE: begin
        round_enable = 1'b1;
        round_index  = r_round;
        // The counter wraps to zero on the final round so it is clean for the next group.
        if (r_round == LAST_ROUND) begin
          w_round_nxt = 5'd0;
          if (!r_last) begin
            w_state_nxt = S_WAIT_INPUT;
          end else if (r_remaining == {OUT_LEN_W{1'b0}}) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_SQUEEZE;
          end
        end else begin
          w_round_nxt = r_round + 5'd1;
          w_state_nxt = S_PERMUTE;
        end
      end
      S_SQUEEZE: begin
        if (!output_buffer_ready) begin
          output_buffer_load = 1'b1;
          last_output_block  = w_rem_le_rate;
          w_remaining_nxt    = w_rem_sub;
          if (w_rem_le_rate) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_round_nxt = 5'd0;
            w_state_nxt = S_PERMUTE;
          end
        end else begin
          w_state_nxt = S_SQUEEZE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
